// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and decoder lock states
package vga_timing_pkg;
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_ACT   = 640;
    localparam int VGA_V_TOTAL = 525;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_ACT   = 480;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: saturating position counter with edge clear and period-length check
// clk, rst(active-low async) | en_i: advance strobe | clr_i: sync edge, restart at 0
// chk_i: enable length check | pos_o: position of the current sample | err_o: bad period length
module vga_axis_counter #(
    parameter int LEN = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       chk_i,
    output logic [9:0] pos_o,
    output logic       err_o
);
    logic [9:0] pos_q, pos_d;
    // Saturation keeps a missing sync from wrapping back into a valid-looking length.
    assign pos_d = !en_i ? pos_q : clr_i ? 10'd0 : (&pos_q) ? pos_q : pos_q + 10'd1;
    assign pos_o = pos_d;
    assign err_o = en_i && clr_i && chk_i && (pos_q != 10'(LEN - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pos_q <= '0;
        else      pos_q <= pos_d;
    end
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers VGA pixel coordinates, verifies timing and checksums locked frames
// clk, rst(active-low async), pix_en: pixel strobe | HS, VS, R, G, B: monitored VGA bus
// de, x, y, pix: active-area pixel | frame_done, frame_sum: per-frame checksum | locked, err: timing status
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int H_ACT    = VGA_H_ACT,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int V_ACT    = VGA_V_ACT,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        HS,
    input  logic        VS,
    input  logic [2:0]  R,
    input  logic [2:0]  G,
    input  logic [1:0]  B,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [7:0]  pix,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic        locked,
    output logic        err
);
    localparam logic [9:0] H_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_HI = 10'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [9:0] V_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_HI = 10'(V_SYNC + V_BP + V_ACT - 1);
    state_e      state_q, state_d;
    logic        hs_s_q, hs_s_d, vs_s_q, vs_s_d;
    logic        de_q, de_d, done_q, done_d, err_q, err_d;
    logic [9:0]  x_q, x_d, y_q, y_d, hpos, vpos;
    logic [7:0]  pix_q, pix_d;
    logic [31:0] sum_q, sum_d, acc_q, acc_d, acc_add;
    logic        hs_a, vs_a, hs_edge, vs_edge, chk, line_err, frame_err, any_err, win, restart, wrap;
    // Sync levels are held internally as "active" so reset means "inactive" for either polarity.
    assign hs_a    = (HS == SYNC_POL);
    assign vs_a    = (VS == SYNC_POL);
    assign hs_edge = pix_en && hs_a && !hs_s_q;
    // VS is only judged at line starts, against its level at the previous line start.
    assign vs_edge = hs_edge && vs_a && !vs_s_q;
    assign hs_s_d  = pix_en ? hs_a : hs_s_q;
    assign vs_s_d  = hs_edge ? vs_a : vs_s_q;
    assign chk     = (state_q != SEARCH);
    vga_axis_counter #(.LEN(H_TOTAL)) u_h (
        .clk(clk), .rst(rst), .en_i(pix_en), .clr_i(hs_edge), .chk_i(chk), .pos_o(hpos), .err_o(line_err)
    );
    vga_axis_counter #(.LEN(V_TOTAL)) u_v (
        .clk(clk), .rst(rst), .en_i(hs_edge), .clr_i(vs_edge), .chk_i(chk), .pos_o(vpos), .err_o(frame_err)
    );
    assign any_err = line_err || frame_err;
    assign state_d = any_err ? SEARCH : !vs_edge ? state_q : (state_q == SEARCH) ? VERIFY : LOCKED;
    assign win     = hpos >= H_LO && hpos <= H_HI && vpos >= V_LO && vpos <= V_HI;
    assign de_d    = pix_en ? (win && state_d == LOCKED) : de_q;
    assign x_d     = (pix_en && win) ? hpos - H_LO : x_q;
    assign y_d     = (pix_en && win) ? vpos - V_LO : y_q;
    assign pix_d   = pix_en ? {R, G, B} : pix_q;
    assign acc_add = acc_q + ((pix_en && de_d) ? {24'd0, pix_d} : 32'd0);
    // A clean VS-edge out of VERIFY or LOCKED starts a fresh sum; only LOCKED publishes it.
    assign restart = vs_edge && chk && !any_err;
    assign wrap    = restart && state_q == LOCKED;
    assign acc_d   = restart ? 32'd0 : acc_add;
    assign sum_d   = wrap ? acc_add : sum_q;
    assign done_d  = wrap;
    assign err_d   = err_q || any_err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
            hs_s_q  <= 1'b0;
            vs_s_q  <= 1'b0;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_s_q  <= hs_s_d;
            vs_s_q  <= vs_s_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end
    assign de         = de_q;
    assign x          = x_q;
    assign y          = y_q;
    assign pix        = pix_q;
    assign frame_done = done_q;
    assign frame_sum  = sum_q;
    assign locked     = (state_q == LOCKED);
    assign err        = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed frames on a reduced raster against both sync polarities
module tb_vga_sync_decoder;
    localparam int HT = 16, HSY = 2, HBP = 2, HA = 10;
    localparam int VT = 10, VSY = 1, VBP = 1, VA = 6;
    logic        clk = 1'b0, rst = 1'b0, pix_en = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [2:0]  r = '0, g = '0;
    logic [1:0]  b = '0;
    logic        hs_n, vs_n;
    logic        de, frame_done, locked, err, de2, done2, locked2, err2;
    logic [9:0]  x, y, x2, y2;
    logic [7:0]  pix, pix2;
    logic [31:0] frame_sum, sum2;
    int          checks = 0, errors = 0;
    int          de_cnt, de_cnt2, done_cnt, fx, fy, lx, ly, drop_v, drop_h;
    bit          seen;
    assign hs_n = ~hs;
    assign vs_n = ~vs;
    always #5 clk = ~clk;
    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HSY), .H_BP(HBP), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VSY), .V_BP(VBP), .V_ACT(VA), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .HS(hs), .VS(vs), .R(r), .G(g), .B(b),
        .de(de), .x(x), .y(y), .pix(pix), .frame_done(frame_done), .frame_sum(frame_sum),
        .locked(locked), .err(err)
    );
    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HSY), .H_BP(HBP), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VSY), .V_BP(VBP), .V_ACT(VA), .SYNC_POL(1'b1)
    ) dut_pos (
        .clk(clk), .rst(rst), .pix_en(pix_en), .HS(hs_n), .VS(vs_n), .R(r), .G(g), .B(b),
        .de(de2), .x(x2), .y(y2), .pix(pix2), .frame_done(done2), .frame_sum(sum2),
        .locked(locked2), .err(err2)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    // One frame: `lines` lines, line short_v one pixel short, a 4x3 box of colour col
    // at active x 2..5, y 1..3, and an async reset pulse at line rst_v, pixel 6.
    task automatic frame(input int lines, input int short_v, input logic [7:0] col, input int rst_v);
        de_cnt = 0; de_cnt2 = 0; done_cnt = 0; seen = 0; drop_v = -1; drop_h = -1;
        for (int v = 0; v < lines; v++) begin
            for (int h = 0; h < ((v == short_v) ? HT - 1 : HT); h++) begin
                bit was_locked;
                if (v == rst_v && h == 6) begin
                    rst = 1'b0;
                    #1;
                    check("rst_de", de, 0);
                    check("rst_x", x, 0);
                    check("rst_locked", locked, 0);
                    check("rst_err", err, 0);
                    check("rst_sum", frame_sum, 0);
                    repeat (3) @(negedge clk);
                    rst = 1'b1;
                end
                was_locked = locked;
                hs = (h >= HSY);
                vs = (v >= VSY);
                {r, g, b} = (h >= HSY + HBP + 2 && h <= HSY + HBP + 5 &&
                             v >= VSY + VBP + 1 && v <= VSY + VBP + 3) ? col : 8'h00;
                pix_en = 1'b1;
                @(negedge clk);
                pix_en = 1'b0;
                if (de) begin
                    if (!seen) begin fx = int'(x); fy = int'(y); seen = 1; end
                    lx = int'(x); ly = int'(y); de_cnt++;
                end
                if (de2) de_cnt2++;
                if (frame_done) done_cnt++;
                if (was_locked && !locked && drop_v < 0) begin drop_v = v; drop_h = h; end
                @(negedge clk);
            end
        end
    endtask
    initial begin
        @(negedge clk);
        check("init_de", de, 0);
        check("init_locked", locked, 0);
        check("init_err", err, 0);
        check("init_sum", frame_sum, 0);
        check("init_done", frame_done, 0);
        rst = 1'b1;
        @(negedge clk);
        frame(VT, -1, 8'hE0, -1);
        check("f1_locked", locked, 0);
        check("f1_de_cnt", de_cnt, 0);
        frame(VT, -1, 8'hE0, -1);
        check("f2_locked", locked, 1);
        check("f2_de_cnt", de_cnt, HA * VA);
        check("f2_first_x", fx, 0);
        check("f2_first_y", fy, 0);
        check("f2_last_x", lx, HA - 1);
        check("f2_last_y", ly, VA - 1);
        check("f2_done_cnt", done_cnt, 0);
        check("f2_pol_de_cnt", de_cnt2, HA * VA);
        check("f2_pol_locked", locked2, 1);
        frame(VT, -1, 8'h1C, -1);
        check("f3_done_cnt", done_cnt, 1);
        check("f3_sum", frame_sum, 2688);
        check("f3_pol_sum", sum2, 2688);
        check("f3_err", err, 0);
        frame(VT, 4, 8'hE0, -1);
        check("f4_sum", frame_sum, 336);
        check("f4_err", err, 1);
        check("f4_locked", locked, 0);
        check("f4_de_cnt", de_cnt, 30);
        check("f4_drop_v", drop_v, 5);
        check("f4_drop_h", drop_h, 0);
        check("f4_pol_err", err2, 1);
        frame(VT, -1, 8'hE0, -1);
        check("f5_locked", locked, 0);
        check("f5_de_cnt", de_cnt, 0);
        frame(VT, -1, 8'h03, -1);
        check("f6_locked", locked, 1);
        check("f6_done_cnt", done_cnt, 0);
        frame(VT, -1, 8'hFF, -1);
        check("f7_done_cnt", done_cnt, 1);
        check("f7_sum", frame_sum, 36);
        check("f7_pol_sum", sum2, 36);
        check("f7_err", err, 1);
        frame(VT - 1, -1, 8'hE0, -1);
        check("f8_sum", frame_sum, 3060);
        frame(VT, -1, 8'hE0, -1);
        check("f9_done_cnt", done_cnt, 0);
        check("f9_sum_hold", frame_sum, 3060);
        check("f9_locked", locked, 0);
        check("f9_pol_locked", locked2, 0);
        frame(VT, -1, 8'hE0, -1);
        check("f10_locked", locked, 0);
        frame(VT, -1, 8'hE0, -1);
        check("f11_locked", locked, 1);
        frame(VT, -1, 8'hE0, 3);
        check("f12_locked", locked, 0);
        frame(VT, -1, 8'hE0, -1);
        check("f13_locked", locked, 0);
        frame(VT, -1, 8'hE0, -1);
        check("f14_locked", locked, 1);
        check("f14_err", err, 0);
        check("f14_pol_locked", locked2, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
